instr_fetch_unit: RTL

//  Parametrised fetch front-end for riscv_processor; replaces the single-register PC/instruction path.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_buffer.sv | 88 ++++++++
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction fetch front-end.
//   NOP_INSTR     : canonical RISC-V NOP (addi x0,x0,0) shown on the debug port when idle.
//   FETCH_XLEN    : width of the address/instruction fields held in a buffer entry.
//   fetch_entry_t : one buffer slot {filled, pc, instr}.
//   ptr_w()       : index width for a power-of-two circular buffer.
package fetch_pkg;

    localparam int          FETCH_XLEN = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef struct packed {
        logic                  filled;
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundles the two handshake channels of the fetch unit.
//   imem_req_* : fetch request to instruction memory (valid/ready, word address)
//   imem_rsp_* : in-order instruction response from memory (valid only, no backpressure)
//   if_*       : {pc, instr} delivery to decode (valid/ready)
// Modports: master = fetch unit side, slave = memory/decode side.
interface fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: circular store of DEPTH fetch entries.
//   alloc_i/alloc_pc_i : reserve the slot at the alloc pointer for a new request
//   fill_i/fill_data_i : write the returned word into the oldest reserved-unfilled slot
//   pop_i              : retire the head slot
//   flush_i            : drop every entry (pointers back to 0); wins over all others
//   full_o             : DEPTH slots reserved
//   unfilled_cnt_o     : slots reserved but still waiting for memory
//   head_valid_o       : head slot reserved and filled
//   head_pc_o/instr_o  : head slot contents
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush_i,
    input  logic                  alloc_i,
    input  logic [FETCH_XLEN-1:0] alloc_pc_i,
    input  logic                  fill_i,
    input  logic [FETCH_XLEN-1:0] fill_data_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic [PW:0]           unfilled_cnt_o,
    output logic                  head_valid_o,
    output logic [FETCH_XLEN-1:0] head_pc_o,
    output logic [FETCH_XLEN-1:0] head_instr_o
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]  alloc_q, alloc_d;
    logic [PW:0]  fill_q, fill_d;
    logic [PW:0]  head_q, head_d;
    logic [PW:0]  reserved;
    fetch_entry_t entries_q [DEPTH];

    assign reserved       = alloc_q - head_q;
    assign full_o         = (reserved == (PW+1)'(DEPTH));
    assign unfilled_cnt_o = alloc_q - fill_q;
    // Slot contents are never reset; an empty buffer masks any stale filled bit.
    assign head_valid_o   = (reserved != '0) && entries_q[head_q[PW-1:0]].filled;
    assign head_pc_o      = entries_q[head_q[PW-1:0]].pc;
    assign head_instr_o   = entries_q[head_q[PW-1:0]].instr;

    always_comb begin
        alloc_d = alloc_q;
        fill_d  = fill_q;
        head_d  = head_q;
        if (flush_i) begin
            alloc_d = '0;
            fill_d  = '0;
            head_d  = '0;
        end else begin
            if (alloc_i) alloc_d = alloc_q + 1'b1;
            if (fill_i)  fill_d  = fill_q + 1'b1;
            if (pop_i)   head_d  = head_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alloc_q <= '0;
            fill_q  <= '0;
            head_q  <= '0;
        end else begin
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            head_q  <= head_d;
        end
    end

    // Alloc and fill never target the same slot: a fill slot is always an
    // older reservation, and a full buffer of unfilled slots cannot pop.
    always_ff @(posedge clk) begin
        if (!flush_i) begin
            if (alloc_i) begin
                entries_q[alloc_d[PW-1:0] - 1'b1].filled <= 1'b0;
                entries_q[alloc_q[PW-1:0]].pc            <= alloc_pc_i;
            end
            if (fill_i) begin
                entries_q[fill_q[PW-1:0]].filled <= 1'b1;
                entries_q[fill_q[PW-1:0]].instr  <= fill_data_i;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: in-order instruction fetch front-end.
//   clk, reset_n        : clock, asynchronous active-low reset
//   redirect_valid/_pc  : flush buffer and restart fetch at redirect_pc & ~3
//   bus (fetch_if)      : imem request/response channels and decode delivery channel
//   pc_out              : head pc when delivering, otherwise the next fetch address
//   instruction_out     : head instruction when delivering, otherwise NOP
//   perf_fetch_cnt/_flush_cnt : saturating delivery / redirect counters
// Build option: define FETCH_PERF_EN to include the performance counters and ports.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    fetch_if.master         bus,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instruction_out
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_fetch_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    localparam int PW = ptr_w(DEPTH);
    // Outstanding-to-discard responses can exceed DEPTH when redirects come
    // faster than memory answers; the extra bits give ample headroom.
    localparam int DW = PW + 5;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [DW-1:0]   drop_q, drop_d;
    logic            buf_full, buf_head_valid;
    logic [PW:0]     buf_unfilled;
    logic [XLEN-1:0] head_pc, head_instr;
    logic            if_valid, pop, req_valid, req_fire, fill;

    assign if_valid  = buf_head_valid && !redirect_valid;
    assign pop       = if_valid && bus.if_ready;
    // A pop frees a slot this cycle, so a full buffer may still request.
    assign req_valid = !redirect_valid && (!buf_full || pop);
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign fill      = !redirect_valid && bus.imem_rsp_valid &&
                       (drop_q == '0) && (buf_unfilled != '0);

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush_i        (redirect_valid),
        .alloc_i        (req_fire),
        .alloc_pc_i     (fetch_pc_q),
        .fill_i         (fill),
        .fill_data_i    (bus.imem_rsp_data),
        .pop_i          (pop),
        .full_o         (buf_full),
        .unfilled_cnt_o (buf_unfilled),
        .head_valid_o   (buf_head_valid),
        .head_pc_o      (head_pc),
        .head_instr_o   (head_instr)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.if_valid       = if_valid;
    assign bus.if_pc          = if_valid ? head_pc : '0;
    assign bus.if_instr       = if_valid ? head_instr : '0;
    assign pc_out             = if_valid ? head_pc : fetch_pc_q;
    assign instruction_out    = if_valid ? head_instr : NOP_INSTR;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            // Every unanswered request becomes a discard; a response landing
            // in this very cycle answers one of them.
            drop_d = drop_q + DW'(buf_unfilled);
            if (bus.imem_rsp_valid && (drop_d != '0)) drop_d = drop_d - DW'(1);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (bus.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] perf_fetch_q, perf_flush_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (pop && !(&perf_fetch_q))            perf_fetch_q <= perf_fetch_q + CNT_W'(1);
            if (redirect_valid && !(&perf_flush_q)) perf_flush_q <= perf_flush_q + CNT_W'(1);
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
